// File: rtl/wrd_pkg.sv
// rtl/wrd_pkg.sv - wake-word datapath shared constants and zero_pad_seq state encoding
package wrd_pkg;

  localparam int WRD_BW         = 8;
  localparam int WRD_VECTOR_LEN = 13;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] GAP    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_STREAM = STREAM,
    ST_DRAIN  = DRAIN,
    ST_GAP    = GAP
  } seq_state_t;

  // Counter width that never collapses to zero bits for single-entry ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zero_pad_seq_if.sv
// rtl/zero_pad_seq_if.sv - vector stream handshake around zero_pad_seq (upstream in, zero_pad out)
interface zero_pad_seq_if
  import wrd_pkg::*;
#(
  parameter int BW         = WRD_BW,
  parameter int VECTOR_LEN = WRD_VECTOR_LEN
);

  logic [VECTOR_LEN*BW-1:0] data_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [VECTOR_LEN*BW-1:0] data_o;
  logic                     valid_o;
  logic                     last_o;
  logic                     ready_i;

  modport slave (
    input  data_i,
    input  valid_i,
    output ready_o,
    output data_o,
    output valid_o,
    output last_o,
    input  ready_i
  );

  modport master (
    output data_i,
    output valid_i,
    input  ready_o,
    input  data_o,
    input  valid_o,
    input  last_o,
    output ready_i
  );

endinterface

// File: rtl/zp_out_reg.sv
// rtl/zp_out_reg.sv - single-entry output register holding data/valid/last with load and accept handshake
module zp_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         load_last,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         last,
  output logic         space,
  output logic         fire
);

  assign fire  = valid & ready;
  assign space = ~valid | ready;

  // Load wins over accept: a same-cycle accept frees the slot the load refills.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
      last  <= load_last;
    end else if (fire) begin
      data  <= '0;
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/zero_pad_seq.sv
// rtl/zero_pad_seq.sv - frame sequencer ahead of zero_pad; ZERO_PAD_SEQ_FRAME_CNT_EN adds frame_cnt_o
module zero_pad_seq
  import wrd_pkg::*;
#(
  parameter int BW         = WRD_BW,
  parameter int VECTOR_LEN = WRD_VECTOR_LEN,
  parameter int FRAME_LEN  = 50,
  parameter int GAP_CYCLES = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           enable_i,
  zero_pad_seq_if.slave  bus,
  output logic           busy_o,
  output logic           frame_done_o
`ifdef ZERO_PAD_SEQ_FRAME_CNT_EN
  ,
  output logic [15:0]    frame_cnt_o
`endif
);

  localparam int DW     = VECTOR_LEN * BW;
  localparam int BEAT_W = cnt_width(FRAME_LEN);
  localparam int GAP_W  = $clog2(GAP_CYCLES);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  seq_state_t        state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              space;
  logic              up_fire;
  logic              dn_fire;
  logic              load_last;

  zp_out_reg #(.W(DW)) u_out_reg (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .load      (up_fire),
    .load_data (bus.data_i),
    .load_last (load_last),
    .ready     (bus.ready_i),
    .data      (bus.data_o),
    .valid     (bus.valid_o),
    .last      (bus.last_o),
    .space     (space),
    .fire      (dn_fire)
  );

  assign bus.ready_o  = (state == ST_STREAM) & space;
  assign up_fire      = bus.valid_i & bus.ready_o;
  assign load_last    = (beat_cnt == BEAT_LAST);
  assign busy_o       = (state != ST_IDLE);
  assign frame_done_o = (state == ST_DRAIN) & dn_fire;

  // enable_i only matters when leaving IDLE or GAP, so a mid-frame drop finishes the frame.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable_i) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (up_fire) begin
            if (load_last) begin
              beat_cnt <= '0;
              state    <= ST_DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (dn_fire) begin
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= enable_i ? ST_STREAM : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ZERO_PAD_SEQ_FRAME_CNT_EN
  logic [15:0] frame_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      frame_cnt <= '0;
    end else if (frame_done_o) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt;
`endif

endmodule
